// File: rtl/conv_pkg.sv
// Shared widths and loader state type for the convolve datapath and its operand loader.
package conv_pkg;

    localparam int SAMPLE_W = 16;
    localparam int PROD_W   = 32;

    typedef enum logic [1:0] {
        LOAD_N = 2'd0,
        LOAD_M = 2'd1,
        HOLD   = 2'd2
    } conv_ld_state_t;

endpackage

// File: rtl/conv_operand_bank.sv
// LEN x SAMPLE_W operand register file, one indexed write per cycle, flat packed read-out.
module conv_operand_bank
    import conv_pkg::*;
#(
    parameter int LEN = 3,
    parameter int CW  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [CW-1:0]           wr_idx,
    input  logic [SAMPLE_W-1:0]     wr_data,
    output logic [LEN*SAMPLE_W-1:0] rd_arr
);

    logic [LEN-1:0][SAMPLE_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < LEN; k++) begin
                if (wr_idx == CW'(k)) begin
                    mem[k] <= wr_data;
                end
            end
        end
    end

    assign rd_arr = mem;

endmodule

// File: rtl/conv_operand_loader.sv
// Streams 16-bit samples into the kernel (N) and signal (M) operand arrays for convolve,
// then holds both arrays with out_valid until the consumer acknowledges them.
//
//  state  | meaning
//  LOAD_N | accepting kernel samples into arr_N, idx = next element
//  LOAD_M | accepting signal samples into arr_M, idx = next element
//  HOLD   | both arrays complete and frozen, out_valid high, waiting for out_ack
module conv_operand_loader
    import conv_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int M  = 5,
    localparam int CW = $clog2(((N > M) ? N : M) + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SAMPLE_W-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N*SAMPLE_W-1:0] out_arr_n,
    output logic [M*SAMPLE_W-1:0] out_arr_m,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [CW-1:0]         idx
);

    conv_ld_state_t state;
    logic           accept;
    logic           wr_n;
    logic           wr_m;

    // Ready depends on state (and reset) only, never on in_valid.
    assign in_ready = ((state == LOAD_N) || (state == LOAD_M)) && !rst;
    assign accept   = in_valid && in_ready;
    assign wr_n     = accept && (state == LOAD_N);
    assign wr_m     = accept && (state == LOAD_M);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD_N;
            idx       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_N: begin
                    if (accept) begin
                        if (idx == CW'(N - 1)) begin
                            idx   <= '0;
                            state <= LOAD_M;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_M: begin
                    if (accept) begin
                        if (idx == CW'(M - 1)) begin
                            idx       <= '0;
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        state     <= LOAD_N;
                    end
                end
                default: begin
                    state     <= LOAD_N;
                    idx       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    conv_operand_bank #(.LEN(N), .CW(CW)) u_bank_n (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_n),
        .wr_idx  (idx),
        .wr_data (in_data),
        .rd_arr  (out_arr_n)
    );

    conv_operand_bank #(.LEN(M), .CW(CW)) u_bank_m (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_m),
        .wr_idx  (idx),
        .wr_data (in_data),
        .rd_arr  (out_arr_m)
    );

endmodule
